// File: rtl/mnist_pkg.sv
// Shared constants, receiver state encoding and pixel-tag layout for the
// MNIST host pixel receiver.
package mnist_pkg;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int PIX_W   = 8;
  localparam int COORD_W = 5;

  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_ACK  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = RX_IDLE,
    ACK  = RX_ACK
  } rx_state_t;

  typedef struct packed {
    logic [PIX_W-1:0]   data;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               last;
  } px_tag_t;

endpackage

// File: rtl/mnist_sync_fifo.sv
// Synchronous FIFO with occupancy count; full/empty derive from the count.
module mnist_sync_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mnist_pixel_rx.sv
// Host pixel receiver: 4-phase req/ack capture, row/column tagging of a
// frame, and FIFO-buffered valid/ready output toward the datapath.
module mnist_pixel_rx
  import mnist_pkg::*;
#(
  parameter int IMG_W      = mnist_pkg::IMG_W,
  parameter int IMG_H      = mnist_pkg::IMG_H,
  parameter int PIX_W      = mnist_pkg::PIX_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [PIX_W-1:0]   host_data,
  input  logic               host_sof,
  input  logic               host_req,
  output logic               host_ack,
  output logic [PIX_W-1:0]   px_data,
  output logic [COORD_W-1:0] px_row,
  output logic [COORD_W-1:0] px_col,
  output logic               px_last,
  output logic               px_valid,
  input  logic               px_ready,
  output logic               frame_err,
  output logic               busy
);

  localparam int TAG_W = PIX_W + 2*COORD_W + 1;
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W-1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H-1);

  rx_state_t          state;
  logic [COORD_W-1:0] row, col;
  logic [COORD_W-1:0] tag_row, tag_col, nxt_row, nxt_col;
  logic               tag_last;
  logic               at_origin;
  logic               capture;
  logic               full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [TAG_W-1:0]   head;

  assign at_origin = (row == '0) && (col == '0);
  assign capture   = (state == IDLE) && host_req && ena && !full;

  // sof forces the tag to the origin regardless of the tracked position
  always_comb begin
    tag_row  = host_sof ? '0 : row;
    tag_col  = host_sof ? '0 : col;
    tag_last = (tag_row == LAST_ROW) && (tag_col == LAST_COL);
    nxt_row  = tag_row;
    nxt_col  = tag_col + 1'b1;
    if (tag_col == LAST_COL) begin
      nxt_col = '0;
      nxt_row = tag_last ? '0 : tag_row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (capture) begin
          state <= ACK;
          row   <= nxt_row;
          col   <= nxt_col;
          if (host_sof && !at_origin) frame_err <= 1'b1;
        end
        ACK: if (!host_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mnist_sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data ({host_data, tag_row, tag_col, tag_last}),
    .rd_en   (px_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign host_ack = (state == ACK);
  assign px_valid = !empty;
  assign {px_data, px_row, px_col, px_last} = empty ? '0 : head;
  assign busy     = !at_origin || (count != '0);

endmodule

// File: tb/tb_mnist_pixel_rx.sv
// Scoreboard bench for mnist_pixel_rx: stimulus queues expected tags,
// a negedge monitor pops and compares on every accepted output.
module tb_mnist_pixel_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] host_data = '0;
  logic       host_sof = 1'b0;
  logic       host_req = 1'b0;
  logic       host_ack;
  logic [7:0] px_data;
  logic [4:0] px_row, px_col;
  logic       px_last, px_valid;
  logic       px_ready = 1'b0;
  logic       frame_err, busy;

  int compared = 0;
  int mismatched = 0;
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  mnist_pixel_rx dut (
    .clk(clk), .rst(rst), .ena(ena),
    .host_data(host_data), .host_sof(host_sof), .host_req(host_req),
    .host_ack(host_ack),
    .px_data(px_data), .px_row(px_row), .px_col(px_col), .px_last(px_last),
    .px_valid(px_valid), .px_ready(px_ready),
    .frame_err(frame_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && px_valid && px_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {13'd0, px_data, px_row, px_col, px_last}, 32'hFFFF_FFFF);
      end else begin
        chk("pop_tag", {13'd0, px_data, px_row, px_col, px_last}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (host_ack !== lvl && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (host_ack !== lvl) chk(name, {31'd0, host_ack}, {31'd0, lvl});
  endtask

  task automatic send(input logic [7:0] d, input logic sof,
                      input logic [4:0] er, input logic [4:0] ec, input logic el);
    host_data = d;
    host_sof  = sof;
    host_req  = 1'b1;
    exp_q.push_back({d, er, ec, el});
    wait_ack(1'b1, "ack_timeout");
    host_req = 1'b0;
    host_sof = 1'b0;
    wait_ack(1'b0, "ack_release_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, host_ack}, 0);
    chk("rst_valid", {31'd0, px_valid}, 0);
    chk("rst_outs", {13'd0, px_data, px_row, px_col, px_last}, 0);
    chk("rst_err_busy", {30'd0, frame_err, busy}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single pixel with sof, ack and head visible one cycle after request
    px_ready  = 1'b1;
    host_data = 8'hA5;
    host_sof  = 1'b1;
    host_req  = 1'b1;
    exp_q.push_back({8'hA5, 5'd0, 5'd0, 1'b0});
    @(posedge clk); #1;
    chk("single_ack", {31'd0, host_ack}, 1);
    chk("single_valid", {31'd0, px_valid}, 1);
    chk("single_head", {13'd0, px_data, px_row, px_col, px_last}, {13'd0, 8'hA5, 5'd0, 5'd0, 1'b0});
    host_req = 1'b0;
    host_sof = 1'b0;
    @(posedge clk); #1;
    chk("single_ack_drop", {31'd0, host_ack}, 0);
    chk("midframe_busy", {31'd0, busy}, 1);

    // reset for two cycles mid-frame
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_outs", {11'd0, host_ack, px_valid, px_data, px_row, px_col, px_last}, 0);
    chk("rst2_busy", {30'd0, frame_err, busy}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // full 28x28 frame
    for (int i = 0; i < 784; i++)
      send(8'(i), i == 0, 5'(i / 28), 5'(i % 28), i == 783);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_err_clean", {31'd0, frame_err}, 0);
    chk("frame_done_busy", {31'd0, busy}, 0);
    chk("frame_sb_empty", exp_q.size(), 0);

    // backpressure: four fill the FIFO, fifth waits for a pop
    px_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(8'hB0 + 8'(i), i == 0, 5'd0, 5'(i), 1'b0);
    host_data = 8'hB4;
    host_req  = 1'b1;
    exp_q.push_back({8'hB4, 5'd0, 5'd4, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    chk("bp_withheld", {31'd0, host_ack}, 0);
    px_ready = 1'b1;
    @(posedge clk); #1;
    px_ready = 1'b0;
    chk("bp_no_bypass", {31'd0, host_ack}, 0);
    @(posedge clk); #1;
    chk("bp_acked", {31'd0, host_ack}, 1);
    host_req = 1'b0;
    wait_ack(1'b0, "bp_release_timeout");
    px_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_sb_empty", exp_q.size(), 0);

    // continue to 100 pixels, then a stray sof
    for (int k = 5; k < 100; k++)
      send(8'(k), 1'b0, 5'(k / 28), 5'(k % 28), 1'b0);
    chk("pre_sof_err", {31'd0, frame_err}, 0);
    send(8'h77, 1'b1, 5'd0, 5'd0, 1'b0);
    chk("midsof_err", {31'd0, frame_err}, 1);
    send(8'h78, 1'b0, 5'd0, 5'd1, 1'b0);
    send(8'h79, 1'b0, 5'd0, 5'd2, 1'b0);
    chk("midsof_sticky", {31'd0, frame_err}, 1);

    // ena low blocks a new handshake
    ena       = 1'b0;
    host_data = 8'h3C;
    host_req  = 1'b1;
    exp_q.push_back({8'h3C, 5'd0, 5'd3, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    chk("ena_low_no_ack", {31'd0, host_ack}, 0);
    ena = 1'b1;
    @(posedge clk); #1;
    chk("ena_high_ack", {31'd0, host_ack}, 1);
    host_req = 1'b0;
    wait_ack(1'b0, "ena_release_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("end_sb_empty", exp_q.size(), 0);
    chk("end_busy_pos", {31'd0, busy}, 1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", {30'd0, frame_err, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mnist_pixel_rx.md
# mnist_pixel_rx

Chip-side receiver for the host pixel stream of the MNIST accelerator. It accepts 8-bit pixels from the dedicated inputs using a 4-phase req/ack handshake and tags each pixel with its row/column in a 28x28 frame. Tagged pixels are buffered in a small FIFO and presented to the inference datapath over a valid/ready interface. It sits between the top-level pin wrapper and the first convolution/MAC stage.

## Interface
Parameters:
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per frame
- PIX_W, 8, pixel width in bits
- FIFO_DEPTH, 4, buffered pixels (power of two, ≥2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  design enable; when low, no new handshakes start
- host_data  in  PIX_W  pixel value, stable while host_req high
- host_sof  in  1  start-of-frame flag, qualified by host_req
- host_req  in  1  host request (4-phase)
- host_ack  out  1  receiver acknowledge
- px_data  out  PIX_W  head-of-FIFO pixel
- px_row  out  5  row of head pixel
- px_col  out  5  column of head pixel
- px_last  out  1  head pixel is (IMG_H-1, IMG_W-1)
- px_valid  out  1  FIFO non-empty
- px_ready  in  1  downstream accepts head when px_valid
- frame_err  out  1  sticky: host_sof seen mid-frame
- busy  out  1  high when a frame is partially received or FIFO non-empty

## Operation
- Reset values: host_ack=0, px_valid=0, px_data/px_row/px_col=0, px_last=0, frame_err=0, busy=0; FSM in IDLE; row=col=0; FIFO empty.
- Handshake FSM (host-side):
  - IDLE: if host_req=1 and ena=1 and FIFO not full → capture {host_data, row, col, last} into FIFO, host_ack←1, go ACK. Otherwise stay (FIFO full withholds ack = backpressure).
  - ACK: host_ack held 1; when host_req=0 → host_ack←0, go IDLE.
- Coordinates: on capture with host_sof=1, pixel tagged (0,0) and next position is (0,1). If host_sof=1 while position ≠ (0,0), set frame_err (sticky until rst) and resynchronise. Without sof, pixel tagged with current position.
- Advance: col increments; at col=IMG_W-1 wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) tag px_last=1 and wrap to (0,0). A pixel at (0,0) without sof is accepted (back-to-back frames).
- FIFO: push on capture, pop when px_valid & px_ready. Push decision uses occupancy at start of cycle (no full-bypass). Simultaneous push+pop on non-full, non-empty FIFO: occupancy unchanged. Pop on empty ignored.
- ena low: IDLE does not capture; ACK still completes (ack drops when req drops); output side keeps draining.
- busy = (position ≠ (0,0)) | px_valid.

## Timing
- host_req seen high at edge N (FIFO not full) → host_ack=1 and px_valid=1 after edge N (1-cycle latency, pixel visible same cycle as ack).
- host_req seen low at edge M in ACK → host_ack=0 after edge M.
- Minimum handshake: 2 cycles per pixel.
- Outputs px_* are registered FIFO-head values; px_valid falls the cycle after the last entry pops.
- rst mid-handshake: host_ack drops next edge, FIFO flushed, coordinates cleared; host must lower req and restart the frame with sof.

## Structure
- Package mnist_pkg: IMG_W, IMG_H, PIX_W, COORD_W=5, rx state enum {IDLE, ACK}, packed pixel-tag struct {data, row, col, last}.
- Sub-module mnist_sync_fifo: parameterised width/depth synchronous FIFO with full/empty/count, sync active-high reset; instantiated once with width PIX_W+11.

## Test plan
- Reset: assert rst 2 cycles mid-frame → all outputs 0, next sof pixel tagged (0,0).
- Single pixel: sof=1, data=0xA5, req high with px_ready=1 → ack after 1 cycle, px_data=0xA5, row=0, col=0, px_last=0.
- Full frame: 784 handshakes, data=index mod 256 → pixel 27 tagged (0,27), pixel 28 tagged (1,0), pixel 783 tagged (27,27) with px_last=1, frame_err=0.
- Backpressure: px_ready=0, send 5 pixels → 4 acked, 5th req held with host_ack=0 until one pop, then acked next cycle.
- Mid-frame sof: after 100 pixels assert sof → frame_err=1 (sticky), that pixel tagged (0,0).
- ena low during req → no ack; raise ena → ack next cycle.
